// File: rtl/req_prio_encoder.sv
// -----------------------------------------------------------------------------
// req_prio_encoder
//   Sequential priority encoder. Request lines are folded into a sticky pending
//   register; the winning pending bit is encoded to a binary index and offered
//   downstream on a valid/ready handshake. Each accepted index clears its bit.
//
//   Build option: define RR_ARB_EN for round-robin selection (search upward
//   from a rotating pointer). Left undefined, the highest pending index wins.
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous, active-high reset
//   en        capture enable; 0 keeps new requests out of pend
//   req[N]    request lines, sampled every clk edge
//   ready     consumer accepts the offered index when high with valid
//   valid     index offer active
//   idx       encoded winning index (held stable while valid)
//   pend[N]   pending register, straight from the flops
//   coalesce  1-cycle pulse: a captured request hit an already-pending bit
// -----------------------------------------------------------------------------
module req_prio_encoder #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [N-1:0]     req,
   input  logic             ready,
   output logic             valid,
   output logic [IDX_W-1:0] idx,
   output logic [N-1:0]     pend,
   output logic             coalesce
);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_OFFER = 1'b1;

   logic [0:0]       state;
   logic [N-1:0]     cap;
   logic [N-1:0]     clr;
   logic [N-1:0]     pend_nxt;
   logic [IDX_W-1:0] enc;
   logic             accept;

   // valid is purely the FSM state, so reset drops it with no clock edge.
   assign valid  = (state == S_OFFER);
   assign accept = valid & ready;
   assign cap    = en ? req : '0;

   always_comb begin
      clr = '0;
      if (accept) clr[idx] = 1'b1;
   end

   // Set after clear: a re-request landing on the accept cycle stays pending.
   assign pend_nxt = (pend & ~clr) | cap;

`ifdef RR_ARB_EN
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] idx_inc;
   logic             found;
   int               j;

   // First set bit at or above ptr, wrapping back through 0.
   always_comb begin
      enc   = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         if (!found && pend[j]) begin
            enc   = IDX_W'(j);
            found = 1'b1;
         end
      end
   end

   assign idx_inc = (idx == IDX_W'(N-1)) ? '0 : idx + IDX_W'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       ptr <= '0;
      else if (accept) ptr <= idx_inc;
   end
`else
   // Ascending scan, last hit wins -> highest set index.
   always_comb begin
      enc = '0;
      for (int i = 0; i < N; i++)
         if (pend[i]) enc = IDX_W'(i);
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         idx      <= '0;
         pend     <= '0;
         coalesce <= 1'b0;
      end else begin
         pend     <= pend_nxt;
         coalesce <= |(cap & pend & ~clr);
         case (state)
            // Encode from the registered pend only; this is the IDLE bubble
            // that sets the 2-cycle req-to-valid latency.
            S_IDLE: begin
               if (|pend) begin
                  idx   <= enc;
                  state <= S_OFFER;
               end
            end
            // idx frozen until the consumer takes it.
            S_OFFER: begin
               if (ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_req_prio_encoder.sv
module tb_req_prio_encoder;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic [3:0] req;
   logic       ready;
   logic       valid;
   logic [1:0] idx;
   logic [3:0] pend;
   logic       coalesce;

   int total = 0;
   int bad   = 0;

   req_prio_encoder #(.N(4), .IDX_W(2)) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .req      (req),
      .ready    (ready),
      .valid    (valid),
      .idx      (idx),
      .pend     (pend),
      .coalesce (coalesce)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Step past the next rising edge; inputs are driven and outputs sampled here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; en = 1'b1; req = '0; ready = 1'b0;
      #1;
      chk("rst_valid", valid, 0);
      chk("rst_idx",   idx,   0);
      chk("rst_pend",  pend,  0);
      chk("rst_coal",  coalesce, 0);
      tick(); tick();
      reset = 1'b0;
      tick();

      // ---- priority, ready=1, one-cycle req=0101
      ready = 1'b1; req = 4'b0101;
      tick();
      req = '0;
      chk("p_pend",   pend, 4'b0101);
      chk("p_valid0", valid, 0);
      tick();
      chk("p_valid1", valid, 1);
`ifdef RR_ARB_EN
      chk("p_idx1", idx, 0);
      tick();
      chk("p_pend1", pend, 4'b0100);
      chk("p_drop1", valid, 0);
      tick();
      chk("p_idx2", idx, 2);
`else
      chk("p_idx1", idx, 2);
      tick();
      chk("p_pend1", pend, 4'b0001);
      chk("p_drop1", valid, 0);
      tick();
      chk("p_idx2", idx, 0);
`endif
      chk("p_valid2", valid, 1);
      tick();
      chk("p_pend2", pend, 0);
      chk("p_drop2", valid, 0);
      tick();
      chk("p_idle", valid, 0);

      // ---- backpressure
      ready = 1'b0; req = 4'b0100;
      tick();
      req = '0;
      tick();
      chk("bp_valid", valid, 1);
      chk("bp_idx",   idx,   2);
      for (int i = 0; i < 10; i++) begin
         req = (i == 3) ? 4'b1000 : 4'b0000;
         tick();
      end
      req = '0;
      chk("bp_hold_v", valid, 1);
      chk("bp_hold_i", idx,   2);
      chk("bp_pend",   pend,  4'b1100);
      ready = 1'b1;
      tick();
      chk("bp_acc_pend", pend, 4'b1000);
      chk("bp_acc_v",    valid, 0);
      tick();
      chk("bp_next_v", valid, 1);
      chk("bp_next_i", idx,   3);
      tick();
      chk("bp_drain", pend, 0);

      // ---- enable gating
      en = 1'b0; req = 4'b1111;
      repeat (5) tick();
      chk("en_pend",  pend,  0);
      chk("en_valid", valid, 0);
      en = 1'b1;
      tick();
      req = '0;
      chk("en_pend1", pend, 4'b1111);
      repeat (8) tick();
      chk("en_drain", pend,  0);
      chk("en_idle",  valid, 0);

      // ---- coalesce / set-wins-over-clear
      ready = 1'b0; req = 4'b0010;
      tick();
      req = '0;
      chk("co_coal0", coalesce, 0);
      tick();
      chk("co_valid", valid, 1);
      chk("co_idx",   idx,   1);
      req = 4'b0010;
      tick();
      req = '0;
      chk("co_pulse", coalesce, 1);
      tick();
      chk("co_one", coalesce, 0);
      ready = 1'b1; req = 4'b0010;
      tick();
      req = '0; ready = 1'b0;
      chk("sw_pend",  pend,     4'b0010);
      chk("sw_coal",  coalesce, 0);
      chk("sw_valid", valid,    0);
      tick();
      chk("sw_revalid", valid, 1);
      chk("sw_reidx",   idx,   1);
      ready = 1'b1;
      tick();
      chk("sw_drain", pend, 0);

      // ---- async reset mid-offer
      ready = 1'b0; req = 4'b0100;
      tick();
      req = '0;
      tick();
      chk("ar_valid", valid, 1);
      chk("ar_idx",   idx,   2);
      #2 reset = 1'b1;
      #1;
      chk("ar_valid0", valid, 0);
      chk("ar_idx0",   idx,   0);
      chk("ar_pend0",  pend,  0);
      tick();
      reset = 1'b0;
      tick(); tick();
      chk("ar_noofr", valid, 0);
      chk("ar_nopnd", pend,  0);

      // ---- held all-request grant sequence
      ready = 1'b1; req = 4'b1111;
      tick();
      for (int g = 0; g < 5; g++) begin
         tick();
         chk("gs_valid", valid, 1);
`ifdef RR_ARB_EN
         chk("gs_idx", idx, g % 4);
`else
         chk("gs_idx", idx, 3);
`endif
         tick();
      end
      req = '0;
      repeat (10) tick();
      chk("gs_drain", pend, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/req_prio_encoder.md
Name: req_prio_encoder

Overview:
- Sequential priority encoder: the encoder side of the team's 2-to-4 enable-gated decoder.
- Captures one-hot or multi-hot request lines into a sticky pending register and encodes the winning request to a binary index.
- Offers each index downstream on a valid/ready handshake; each accepted index clears its pending bit.
- Sits between event sources (buttons, timers, peripheral flags) and a consumer that drives the index back into a decoder or mux.

Parameters:
N, 4, number of request lines (N >= 2).
IDX_W, 2, index width; must equal ceil(log2(N)).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
en  input  1  capture enable; 0 blocks new requests from entering pending.
req  input  N  request lines, sampled every clk edge (level or pulse).
ready  input  1  consumer accepts the offered index when high with valid.
valid  output  1  index offer active.
idx  output  IDX_W  encoded winning request index.
pend  output  N  current pending register.
coalesce  output  1  1-cycle pulse: a captured request hit an already-pending bit.

Behaviour:
- Reset (async, immediate): valid=0, idx=0, pend=0, coalesce=0, FSM=IDLE.
- Capture mask cap = en ? req : 0.
- Clear mask clr = one-hot(idx) when valid & ready are sampled high, else 0.
- pend_next = (pend & ~clr) | cap. Set wins over clear on the same bit, so a re-request on the accept cycle stays pending.
- coalesce_next = |(cap & pend & ~clr). Registered, high for exactly one cycle.
- FSM IDLE:
  - If pend != 0, load idx = encode(pend), set valid=1, go to OFFER.
  - Otherwise hold valid=0; idx keeps its last value.
- FSM OFFER:
  - valid=1 and idx are held stable regardless of new requests, until ready is sampled high.
  - On accept: clear pend[idx], valid=0, return to IDLE.
- Encode (default): the highest set index of pend wins.
- Latency: req sampled at edge k sets pend after k; valid is high after edge k+1 (2 cycles req-to-valid from IDLE).
- Throughput: one grant per 2 cycles (one IDLE bubble between grants).
- ready with valid=0 is ignored.
- en toggling never affects an offer in progress; already-pending bits are still served when en=0.
- pend output is exactly the register, no combinational bypass.

Optional Feature:
Macro RR_ARB_EN.
- Defined:
  - Round-robin encode using register ptr (IDX_W bits, reset 0).
  - Search pend upward from ptr, wrapping; the first set bit wins.
  - On accept, ptr = (idx+1) mod N.
- Undefined:
  - Fixed priority, highest index wins.
  - No ptr register exists.

Test Plan:
1. Reset: assert reset mid-OFFER (valid=1, idx=2) -> valid=0, idx=0, pend=0 immediately without a clk edge; after release, no offer until a new req.
2. Fixed priority, N=4, ready=1: one-cycle req=4'b0101 -> pend=0101; valid high with idx=2, accepted; next offer idx=0, accepted; then pend=0000 and valid=0.
3. Backpressure: req=4'b0100 then ready=0 for 10 cycles; req=4'b1000 mid-stall -> idx stays 2 with valid held high; pend=1100; after ready=1, next grant idx=3.
4. Enable gating: en=0, req=4'b1111 for 5 cycles -> pend=0000, valid=0; en=1 for one cycle -> pend=1111.
5. Simultaneous events, with pend[1]=1 offered:
   - req[1] pulse while not accepting -> coalesce=1 for one cycle.
   - req[1] on the accept cycle -> pend[1] stays 1, coalesce=0, idx=1 re-offered after the IDLE bubble.
6. RR_ARB_EN defined: req=4'b1111 held with ready=1 -> grant sequence idx=0,1,2,3,0; with it undefined -> idx=3 repeated.
